// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//
// Shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : encodings of the mode input and active mode.
//   dir_e                   : counting direction of the shared timebase.
//   ch_idx_width()          : width of the duty write channel index for a
//                             given channel count (at least one bit).
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A single channel still needs a one-bit index port.
    function automatic int ch_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//
// Shared counter for all PWM channels. Holds the counter, its direction, and
// the active (double-buffered) period and mode. Emits a load strobe on every
// clock edge at which the active registers take new values; the top level
// uses the same strobe to copy pending duties into the active duties.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset
//   enable  in   run the timebase; low holds cnt at 0 and loads every cycle
//   mode    in   requested mode (MODE_EDGE / MODE_CENTER), taken at loads
//   period  in   requested period P, taken at loads
//   cnt     out  current counter value
//   load    out  high when the current edge is a period boundary / load edge
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] cnt,
    output logic             load
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dir_e             dir;
    dir_e             dir_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] p_act;
    logic             mode_act;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            p_act    <= '0;
            mode_act <= MODE_EDGE;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (load) begin
                p_act    <= period;
                mode_act <= mode;
            end
        end
    end

    // Boundary decode: when does the current period end?
    // Edge mode uses >= so an out-of-range count also wraps with a load.
    // Center mode ends on the way down at 1, or straight after the peak when
    // P=1 (no down leg), or every cycle when P=0.
    always_comb begin
        load = 1'b0;
        if (!enable) begin
            load = 1'b1;
        end else if (mode_act == MODE_EDGE) begin
            load = (cnt >= p_act);
        end else if (p_act == '0) begin
            load = 1'b1;
        end else if (dir == DIR_UP) begin
            load = (cnt >= p_act) && (p_act == ONE);
        end else begin
            load = (cnt <= ONE);
        end
    end

    // Next-state logic for the counter and its direction.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (load) begin
            // Every period, and every mode change, restarts at 0 counting up.
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (mode_act == MODE_EDGE) begin
            cnt_nxt = cnt + ONE;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt >= p_act) begin
                // Peak reached: the next value is already on the down leg.
                cnt_nxt = p_act - ONE;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end else begin
            cnt_nxt = cnt - ONE;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. One shared timebase (pwm_timebase) drives
// CHANNELS independent duty comparators. Duties are double-buffered: writes
// land in a pending register and reach the comparator only at a load edge,
// so a period never mixes old and new settings.
//
// Parameters:
//   CHANNELS  number of PWM outputs (1..16)
//   WIDTH     counter, period and duty width (4..16)
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   enable        in   run timebase; low forces outputs idle
//   mode          in   0 = edge-aligned, 1 = center-aligned (taken at loads)
//   period        in   period value P (taken at loads)
//   duty_wr_en    in   write strobe for a pending duty register
//   duty_wr_ch    in   target channel; indices >= CHANNELS are ignored
//   duty_wr_data  in   duty value D
//   pwm_out       out  registered PWM outputs, one per channel
//   period_start  out  registered pulse on the first output cycle of a period
// -----------------------------------------------------------------------------
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                mode,
    input  logic [WIDTH-1:0]                    period,
    input  logic                                duty_wr_en,
    input  logic [ch_idx_width(CHANNELS)-1:0]   duty_wr_ch,
    input  logic [WIDTH-1:0]                    duty_wr_data,
    output logic [CHANNELS-1:0]                 pwm_out,
    output logic                                period_start
);

    localparam int CH_W = ch_idx_width(CHANNELS);

    logic [WIDTH-1:0]    cnt;
    logic                load;
    logic [CHANNELS-1:0] pwm_nxt;

    pwm_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .period (period),
        .cnt    (cnt),
        .load   (load)
    );

    // Per-channel shadow registers and comparator.
    // Channel indices >= CHANNELS match no generated channel, so such writes
    // fall on the floor without any explicit range check.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty_pend;
        logic [WIDTH-1:0] duty_act;
        logic             wr_hit;

        assign wr_hit = duty_wr_en && (duty_wr_ch == CH_W'(i));

        // NOTE: the duty registers are reset explicitly because their value is
        // visible on pwm_out straight after reset; they are flops, not a RAM.
        always_ff @(posedge clk) begin
            if (reset) begin
                duty_pend <= '0;
                duty_act  <= '0;
            end else begin
                // A write on a load edge stays pending: the load copies the
                // pre-edge pending value.
                if (wr_hit) begin
                    duty_pend <= duty_wr_data;
                end
                if (load) begin
                    duty_act <= duty_pend;
                end
            end
        end

        assign pwm_nxt[i] = enable && (cnt < duty_act);
    end

    // Registered outputs: one cycle behind the counter value they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pwm_nxt;
            period_start <= enable && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//
// Self-checking bench for pwm_multi (CHANNELS=4, WIDTH=8). Directed scenario
// tasks compare high-time counts and period_start spacing against values
// worked out from the PWM rules; a randomized phase compares every output
// cycle against a position-in-period reference model.
// -----------------------------------------------------------------------------
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 8;
    localparam int CH_W     = ch_idx_width(CHANNELS);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                mode = 1'b0;
    logic [WIDTH-1:0]    period = '0;
    logic                duty_wr_en = 1'b0;
    logic [CH_W-1:0]     duty_wr_ch = '0;
    logic [WIDTH-1:0]    duty_wr_data = '0;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    int errors = 0;
    int checks = 0;

    // Measurement accumulators.
    int          hi_cnt[CHANNELS];
    int          ps_cnt;
    logic [15:0] pat0;

    pwm_multi #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_data (duty_wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: tracks the position inside the current period and
    // derives the counter value from it. The outputs it predicts after each
    // edge describe the cycle that just ended.
    // ------------------------------------------------------------------------
    int                  m_pos = 0;
    int                  m_p = 0;
    logic                m_mode = 1'b0;
    logic [WIDTH-1:0]    m_pend[CHANNELS];
    logic [WIDTH-1:0]    m_act[CHANNELS];
    logic [CHANNELS-1:0] exp_pwm = '0;
    logic                exp_ps = 1'b0;

    function automatic int period_len(input int p, input logic md);
        if (md == MODE_EDGE) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    function automatic int cnt_at(input int p, input logic md, input int pos);
        if (md == MODE_EDGE) return pos;
        return (pos <= p) ? pos : 2 * p - pos;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_pos   = 0;
                m_p     = 0;
                m_mode  = MODE_EDGE;
                exp_pwm = '0;
                exp_ps  = 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    m_pend[i] = '0;
                    m_act[i]  = '0;
                end
            end else begin
                int  c;
                bit  boundary;
                c      = cnt_at(m_p, m_mode, m_pos);
                exp_ps = enable && (m_pos == 0);
                for (int i = 0; i < CHANNELS; i++)
                    exp_pwm[i] = enable && (c < int'(m_act[i]));
                boundary = !enable || (m_pos + 1 >= period_len(m_p, m_mode));
                if (boundary) begin
                    m_pos  = 0;
                    m_p    = int'(period);
                    m_mode = mode;
                    for (int i = 0; i < CHANNELS; i++) m_act[i] = m_pend[i];
                end else begin
                    m_pos++;
                end
                if (duty_wr_en && int'(duty_wr_ch) < CHANNELS)
                    m_pend[duty_wr_ch] = duty_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus / measurement helpers (all run from negedge to negedge).
    // ------------------------------------------------------------------------
    task automatic write_duty(input int ch, input int d);
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_W'(ch);
        duty_wr_data = WIDTH'(d);
        @(negedge clk);
        duty_wr_en   = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CHANNELS; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
        pat0   = '0;
    endtask

    // Sample the current output cycle and advance, n times.
    task automatic measure(input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CHANNELS; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (period_start) ps_cnt++;
            pat0 = {pat0[14:0], pwm_out[0]};
            @(negedge clk);
        end
    endtask

    // Advance until a sample shows period_start (at least one step).
    task automatic sync(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 1200);
        checks++;
        if (!period_start) begin
            errors++;
            $display("FAIL %s_sync: no period_start within %0d cycles", tag, n);
        end
    endtask

    // Two boundaries, so the second period surely uses settings applied now.
    task automatic settle(input string tag);
        sync(tag);
        sync(tag);
    endtask

    task automatic cycles_to_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 1200);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== '0) begin
            errors++;
            $display("FAIL reset_pwm: got %b expected 0", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ps: got %b expected 0", period_start);
        end
        checks++;
        if (u_dut.u_timebase.cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", u_dut.u_timebase.cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== '0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got pwm=%b ps=%b expected 0/0", pwm_out, period_start);
        end
    endtask

    task automatic test_edge();
        int exp_hi[CHANNELS] = '{0, 3, 10, 10};
        mode   = MODE_EDGE;
        period = 8'd9;
        write_duty(0, 0);
        write_duty(1, 3);
        write_duty(2, 10);
        write_duty(3, 255);
        enable = 1'b1;
        settle("edge");
        clear_counts();
        measure(10);
        for (int i = 0; i < CHANNELS; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL edge_hi_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
        checks++;
        if (ps_cnt !== 1 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL edge_ps_spacing: got count=%0d next=%b expected 1/1", ps_cnt, period_start);
        end
    endtask

    task automatic test_center();
        int exp_hi[CHANNELS] = '{3, 0, 7, 8};
        mode   = MODE_CENTER;
        period = 8'd4;
        write_duty(0, 2);
        write_duty(1, 0);
        write_duty(2, 4);
        write_duty(3, 5);
        settle("center");
        clear_counts();
        measure(8);
        for (int i = 0; i < CHANNELS; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL center_hi_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
        // cnt 0,1,2,3,4,3,2,1 with D=2 -> high at 0,1 and the final 1
        checks++;
        if (pat0[7:0] !== 8'b1100_0001) begin
            errors++;
            $display("FAIL center_shape_ch0: got %b expected 11000001", pat0[7:0]);
        end
        checks++;
        if (ps_cnt !== 1 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL center_ps_spacing: got count=%0d next=%b expected 1/1", ps_cnt, period_start);
        end
        // P=0 in center mode: counter parks at 0, every cycle is a period.
        period = 8'd0;
        settle("center_p0");
        clear_counts();
        measure(5);
        checks++;
        if (ps_cnt !== 5 || hi_cnt[3] !== 5 || hi_cnt[1] !== 0) begin
            errors++;
            $display("FAIL center_p0: got ps=%0d hi3=%0d hi1=%0d expected 5/5/0",
                     ps_cnt, hi_cnt[3], hi_cnt[1]);
        end
    endtask

    task automatic test_duty_update();
        mode   = MODE_EDGE;
        period = 8'd9;
        write_duty(1, 2);
        settle("dupd");
        // Mid-period write: current period keeps D=2.
        clear_counts();
        duty_wr_en = 1'b1; duty_wr_ch = CH_W'(1); duty_wr_data = 8'd5;
        measure(1);
        duty_wr_en = 1'b0;
        measure(9);
        checks++;
        if (hi_cnt[1] !== 2 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL dupd_old: got hi=%0d ps=%b expected 2/1", hi_cnt[1], period_start);
        end
        clear_counts();
        measure(10);
        checks++;
        if (hi_cnt[1] !== 5) begin
            errors++;
            $display("FAIL dupd_new: got %0d expected 5", hi_cnt[1]);
        end
        // Write on the load edge itself: takes one extra period.
        clear_counts();
        measure(8);
        duty_wr_en = 1'b1; duty_wr_ch = CH_W'(1); duty_wr_data = 8'd7;
        measure(1);
        duty_wr_en = 1'b0;
        measure(1);
        clear_counts();
        measure(10);
        checks++;
        if (hi_cnt[1] !== 5) begin
            errors++;
            $display("FAIL dupd_loadedge_first: got %0d expected 5", hi_cnt[1]);
        end
        clear_counts();
        measure(10);
        checks++;
        if (hi_cnt[1] !== 7) begin
            errors++;
            $display("FAIL dupd_loadedge_second: got %0d expected 7", hi_cnt[1]);
        end
    endtask

    task automatic test_period_change();
        int n1, n2, n3;
        mode   = MODE_EDGE;
        period = 8'd9;
        settle("pchg");
        clear_counts();
        measure(3);
        period = 8'd3;
        cycles_to_ps(n1);
        cycles_to_ps(n2);
        cycles_to_ps(n3);
        checks++;
        if (n1 + 3 !== 10) begin
            errors++;
            $display("FAIL pchg_old_period: got %0d expected 10", n1 + 3);
        end
        checks++;
        if (n2 !== 4 || n3 !== 4) begin
            errors++;
            $display("FAIL pchg_new_period: got %0d,%0d expected 4,4", n2, n3);
        end
    endtask

    task automatic test_reset_mid();
        write_duty(0, 5);
        settle("rmid");
        clear_counts();
        measure(2);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm_out !== '0 || period_start !== 1'b0 || u_dut.u_timebase.cnt !== '0) begin
            errors++;
            $display("FAIL rmid_state: got pwm=%b ps=%b cnt=%0d expected 0/0/0",
                     pwm_out, period_start, u_dut.u_timebase.cnt);
        end
        reset = 1'b0;
        clear_counts();
        measure(12);
        checks++;
        if (hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] !== 0) begin
            errors++;
            $display("FAIL rmid_quiet: got %0d high cycles expected 0",
                     hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]);
        end
        write_duty(0, 2);
        settle("rmid_dw");
        clear_counts();
        measure(4);
        checks++;
        if (hi_cnt[0] !== 2 || ps_cnt !== 1) begin
            errors++;
            $display("FAIL rmid_recover: got hi=%0d ps=%0d expected 2/1", hi_cnt[0], ps_cnt);
        end
    endtask

    task automatic test_enable_toggle();
        // P=3 edge mode, ch0 D=2 from the previous scenario.
        sync("en");
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== '0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL en_off: got pwm=%b ps=%b expected 0/0", pwm_out, period_start);
        end
        write_duty(2, 3);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (period_start !== 1'b1 || pwm_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL en_restart: got ps=%b pwm2=%b expected 1/1", period_start, pwm_out[2]);
        end
        clear_counts();
        measure(4);
        checks++;
        if (hi_cnt[0] !== 2 || hi_cnt[2] !== 3 || ps_cnt !== 1) begin
            errors++;
            $display("FAIL en_period: got hi0=%0d hi2=%0d ps=%0d expected 2/3/1",
                     hi_cnt[0], hi_cnt[2], ps_cnt);
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0)
                period = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 12));
            duty_wr_en = ($urandom_range(0, 3) == 0);
            duty_wr_ch = CH_W'($urandom_range(0, CHANNELS - 1));
            duty_wr_data = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                                       : 8'($urandom_range(0, 255));
            @(negedge clk);
            checks++;
            if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
                errors++;
                $display("FAIL rand_cycle%0d: got pwm=%b ps=%b expected pwm=%b ps=%b",
                         k, pwm_out, period_start, exp_pwm, exp_ps);
            end
        end
        reset      = 1'b0;
        duty_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_duty_update();
        test_period_change();
        test_reset_mid();
        test_enable_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator for the synthesizer's audio output stage. One shared timebase drives CHANNELS independent duty comparators. Supports edge-aligned and center-aligned modes. Period and duties are double-buffered, so updates take effect only at a period boundary and produce no glitched or partial cycles. It sits between the voice/mixer register interface and the output pins, and replaces the single-channel PWM.

## Interface

Parameters:
- CHANNELS, default 4: number of PWM outputs (1..16).
- WIDTH, default 8: counter, period and duty width in bits (4..16).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  run timebase; low forces idle.
- mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at load edges only.
- period  in  WIDTH  period value P; sampled at load edges only.
- duty_wr_en  in  1  write strobe for the pending duty register.
- duty_wr_ch  in  max(1,$clog2(CHANNELS))  target channel; writes to channels ≥ CHANNELS are ignored.
- duty_wr_data  in  WIDTH  duty value D.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  registered 1-cycle pulse marking the first output cycle of each period.

## Operation

- State:
  - counter cnt[WIDTH-1:0]
  - direction bit dir (0 = up)
  - per channel: duty_pend and duty_act
  - active period P_act and mode_act
- Reset: cnt=0, dir=up, all duty_pend/duty_act=0, P_act=0, mode_act=0, pwm_out=0, period_start=0.
- Duty writes update duty_pend[duty_wr_ch] on any cycle, whether or not enable is high.
- Load edge: active registers are loaded on it: duty_act ← duty_pend (pre-edge value), P_act ← period, mode_act ← mode. A write on the same cycle as a load lands in pending only and takes effect at the following boundary.
- enable=0:
  - cnt←0, dir←up, pwm_out←0, period_start←0.
  - A load occurs every cycle, so the shadows stay transparent.
- Edge mode, enable=1:
  - If cnt==P_act: cnt←0 with a load; otherwise cnt←cnt+1.
  - Sequence is 0..P, period P+1 cycles.
- Center mode, enable=1:
  - Sequence 0,1..P,P-1..1, then 0 with a load; period 2P cycles.
  - dir flips to down at cnt==P and back to up on the load to 0.
  - P_act=0: cnt stays 0 and a load occurs every cycle.
- Compare: pwm_out[i] ← enable & (cnt < duty_act[i]), an unsigned comparison.
  - Edge mode: high time is min(D, P+1) cycles per period.
  - Center mode: high time is 2D−1 cycles for 1≤D≤P, 0 for D=0, and the full period for D>P. Output is symmetric about cnt=P.
  - D=0 gives a constant low output; D>P gives a constant high output.
- Out-of-range cnt: if cnt > P_act (not reachable in normal operation), edge mode wraps to 0 with a load on the next cycle.
- period_start ← enable & (cnt==0), so it is aligned with pwm_out of the first cycle of each period.
- Reset has priority over everything, including in the middle of a period.

## Timing

- Output latency: 1 cycle from the counter value to pwm_out (registered compare).
- enable rising at edge k:
  - cnt=0 during cycle k+1, using values loaded at edge k.
  - First pwm_out and period_start are valid after edge k+1.
- enable falling: pwm_out goes 0 one edge later and stays 0.
- Duty write at edge w: the new value is visible on pwm_out starting 1 cycle after the first load edge strictly after w.
- A period change takes effect at the next boundary. The current period always completes with its old P.
- Mode change takes effect at the next boundary, where the counter restarts at 0 counting up.
- No combinational paths from input to output.

## Structure

- Package pwm_pkg holds:
  - localparams MODE_EDGE=1'b0 and MODE_CENTER=1'b1
  - a function giving the width of duty_wr_ch from CHANNELS
- Sub-module pwm_timebase holds cnt, dir, the load pulse and P_act/mode_act. The top level owns the per-channel shadow registers and comparators in a generate loop.

## Test plan

- Edge mode, WIDTH=8, P=9, D={0,3,10,255}, enable held high → per 10-cycle period, channel high counts {0,3,10,10}; period_start every 10 cycles.
- Center mode, P=4, D=2 → cnt sequence 0,1,2,3,4,3,2,1; pwm_out high for 3 of 8 cycles (cnt 0,1,1), symmetric about cnt=4.
- Write D=5 to ch1 mid-period with P=9 (old D=2) → remainder of the current period still shows 2 high cycles; next period shows 5. A write in the same cycle as the load edge appears one period later.
- Change P 9→3 mid-period → the current period completes at 10 cycles; subsequent periods are 4 cycles; period_start spacing is 10 then 4.
- Assert reset mid-period with D=5 → after the edge, pwm_out=0, period_start=0, cnt=0. After release with enable high, outputs stay 0 until a duty is written and a boundary passes.
- Toggle enable low for 3 cycles mid-period → pwm_out is 0 one edge after enable falls. On re-enable, cnt restarts at 0 with pending values loaded, and period_start fires 1 cycle after enable returns.
